// File: rtl/t1_event_recorder_pkg.sv
// t1_event_recorder_pkg: shared trigger definitions for the T1 event recorder.
// Holds default field widths and the event-word packing order
// {evnum, time, offset, matched}, MSB first.
package t1_event_recorder_pkg;
  localparam int unsigned SCALER_NUM_L4      = 5;
  localparam int unsigned T1_OFFSET_BITS     = 9;
  localparam int unsigned EV_TIME_BITS       = 32;
  localparam int unsigned EV_NUM_BITS        = 16;
  localparam int unsigned EV_FIFO_DEPTH_LOG2 = 4;
  localparam int unsigned EV_DROP_BITS       = 16;
  function automatic int unsigned event_word_bits(input int unsigned evnum_bits, input int unsigned time_bits,
                                                  input int unsigned offset_bits, input int unsigned num_l4);
    return evnum_bits + time_bits + offset_bits + num_l4;
  endfunction
endpackage

// File: rtl/t1_event_fifo.sv
// t1_event_fifo: generic synchronous show-ahead FIFO.
// Ports: clk, rst (sync, active high), wr_en/din push, rd_en pop,
// dout head word (0 when empty), full, empty, count occupancy 0..2^DEPTH_LOG2.
module t1_event_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  logic [WIDTH-1:0]    mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                do_rd, do_wr;
  // extra pointer bit tells full (MSBs differ) from empty (pointers equal)
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}};
  assign count = wr_ptr - rd_ptr;
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);
  // masking keeps stale contents invisible after reset
  assign dout  = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/t1_event_recorder.sv
// t1_event_recorder: records accepted T1 pulses as event words into a FIFO stream.
// Ports: clk_i, rst_i (sync, active high); T1_i/T1_offset_i/l4_matched_i trigger input;
// disable_i/disable_ce_i recording disable load; evt_* valid/ready head stream;
// fifo_count_o occupancy; drop_count_o saturating drop count; overflow_o sticky drop flag.
module t1_event_recorder
  import t1_event_recorder_pkg::*;
#(
  parameter int unsigned NUM_L4          = SCALER_NUM_L4,
  parameter int unsigned OFFSET_BITS     = T1_OFFSET_BITS,
  parameter int unsigned TIME_BITS       = EV_TIME_BITS,
  parameter int unsigned EVNUM_BITS      = EV_NUM_BITS,
  parameter int unsigned FIFO_DEPTH_LOG2 = EV_FIFO_DEPTH_LOG2,
  parameter int unsigned DROP_BITS       = EV_DROP_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       T1_i,
  input  logic [OFFSET_BITS-1:0]     T1_offset_i,
  input  logic [NUM_L4-1:0]          l4_matched_i,
  input  logic                       disable_i,
  input  logic                       disable_ce_i,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [EVNUM_BITS-1:0]      evt_num_o,
  output logic [TIME_BITS-1:0]       evt_time_o,
  output logic [OFFSET_BITS-1:0]     evt_offset_o,
  output logic [NUM_L4-1:0]          evt_matched_o,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count_o,
  output logic [DROP_BITS-1:0]       drop_count_o,
  output logic                       overflow_o
);
  localparam int unsigned W = event_word_bits(EVNUM_BITS, TIME_BITS, OFFSET_BITS, NUM_L4);
  logic [TIME_BITS-1:0]  tstamp;
  logic [EVNUM_BITS-1:0] evnum;
  logic                  disabled, full, empty, pop, accept, drop;
  logic [W-1:0]          head;
  assign pop    = evt_valid_o & evt_ready_i;
  // a pop on the same edge frees the slot a full FIFO needs
  assign accept = T1_i & ~disabled & (~full | pop);
  assign drop   = T1_i & ~disabled & full & ~pop;
  assign evt_valid_o = ~empty;
  assign {evt_num_o, evt_time_o, evt_offset_o, evt_matched_o} = head;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      tstamp       <= '0;
      evnum        <= '0;
      disabled     <= 1'b0;
      drop_count_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      tstamp <= tstamp + 1'b1;
      if (disable_ce_i) disabled <= disable_i;
      if (accept) evnum <= evnum + 1'b1;
      if (drop) begin
        if (~&drop_count_o) drop_count_o <= drop_count_o + 1'b1;
        overflow_o <= 1'b1;
      end
    end
  t1_event_fifo #(
    .WIDTH      (W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .wr_en (accept),
    .din   ({evnum, tstamp, T1_offset_i, l4_matched_i}),
    .rd_en (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_o)
  );
endmodule

// File: tb/tb_t1_event_recorder.sv
// tb_t1_event_recorder: scoreboard bench for t1_event_recorder.
module tb_t1_event_recorder;
  typedef struct {
    logic [15:0] num;
    logic [31:0] t;
    logic [8:0]  off;
    logic [4:0]  m;
  } ev_t;
  logic        clk = 0, rst_i = 0, T1_i = 0, disable_i = 0, disable_ce_i = 0, evt_ready_i = 0;
  logic [8:0]  T1_offset_i = 0;
  logic [4:0]  l4_matched_i = 0;
  logic        evt_valid_o, overflow_o;
  logic [15:0] evt_num_o, drop_count_o;
  logic [31:0] evt_time_o;
  logic [8:0]  evt_offset_o;
  logic [4:0]  evt_matched_o;
  logic [4:0]  fifo_count_o;
  logic        t1_w = 0, ready_w = 0, valid_w, ovf_w;
  logic [1:0]  num_w;
  logic [3:0]  time_w;
  logic [8:0]  off_w;
  logic [4:0]  m_w, cnt_w;
  logic [15:0] drop_w;
  int vectors = 0, miscompares = 0;
  ev_t q[$];
  logic [31:0] ts = 0;
  logic [15:0] ev_m = 0, drop_m = 0;
  logic        dis_m = 0, ovf_m = 0;
  always #5 clk = ~clk;
  t1_event_recorder dut (
    .clk_i(clk), .rst_i(rst_i), .T1_i(T1_i), .T1_offset_i(T1_offset_i), .l4_matched_i(l4_matched_i),
    .disable_i(disable_i), .disable_ce_i(disable_ce_i), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_num_o(evt_num_o), .evt_time_o(evt_time_o), .evt_offset_o(evt_offset_o), .evt_matched_o(evt_matched_o),
    .fifo_count_o(fifo_count_o), .drop_count_o(drop_count_o), .overflow_o(overflow_o)
  );
  t1_event_recorder #(.TIME_BITS(4), .EVNUM_BITS(2)) dut_w (
    .clk_i(clk), .rst_i(rst_i), .T1_i(t1_w), .T1_offset_i(9'd0), .l4_matched_i(5'd0),
    .disable_i(1'b0), .disable_ce_i(1'b0), .evt_valid_o(valid_w), .evt_ready_i(ready_w),
    .evt_num_o(num_w), .evt_time_o(time_w), .evt_offset_o(off_w), .evt_matched_o(m_w),
    .fifo_count_o(cnt_w), .drop_count_o(drop_w), .overflow_o(ovf_w)
  );
  task automatic tick();
    @(posedge clk);
    ts = rst_i ? 32'd0 : ts + 1;
    #1;
  endtask
  task automatic cycle(input logic t1, input logic [8:0] off, input logic [4:0] m, input logic rdy);
    ev_t e;
    int sz;
    bit pop, acc;
    T1_i = t1; T1_offset_i = off; l4_matched_i = m; evt_ready_i = rdy;
    if (rst_i) begin
      q.delete(); ev_m = 0; drop_m = 0; ovf_m = 0; dis_m = 0;
    end else begin
      sz = q.size();
      vectors++;
      if (evt_valid_o !== (sz > 0)) begin
        miscompares++; $display("FAIL valid: got %0b exp %0b", evt_valid_o, sz > 0);
      end
      pop = rdy && sz > 0;
      if (pop) begin
        e = q.pop_front();
        vectors++;
        if ({evt_num_o, evt_time_o, evt_offset_o, evt_matched_o} !== {e.num, e.t, e.off, e.m}) begin
          miscompares++;
          $display("FAIL head: got num=%0d time=%0d off=%0d m=%0h exp num=%0d time=%0d off=%0d m=%0h",
                   evt_num_o, evt_time_o, evt_offset_o, evt_matched_o, e.num, e.t, e.off, e.m);
        end
      end
      acc = t1 && !dis_m && (sz < 16 || pop);
      if (acc) begin
        q.push_back('{ev_m, ts, off, m}); ev_m++;
      end else if (t1 && !dis_m) begin
        if (drop_m != 16'hffff) drop_m++;
        ovf_m = 1;
      end
      if (disable_ce_i) dis_m = disable_i;
    end
    tick();
    T1_i = 0; evt_ready_i = 0;
    vectors++;
    if (fifo_count_o !== 5'(q.size()) || drop_count_o !== drop_m || overflow_o !== ovf_m) begin
      miscompares++;
      $display("FAIL status: got cnt=%0d drop=%0d ovf=%0b exp cnt=%0d drop=%0d ovf=%0b",
               fifo_count_o, drop_count_o, overflow_o, q.size(), drop_m, ovf_m);
    end
  endtask
  task automatic do_reset();
    rst_i = 1;
    cycle(0, 0, 0, 0);
    rst_i = 0;
  endtask
  task automatic test_reset();
    disable_i = 0; disable_ce_i = 0;
    do_reset();
    do_reset();
    vectors++;
    if ({evt_valid_o, evt_num_o, evt_time_o, evt_offset_o, evt_matched_o, fifo_count_o, drop_count_o, overflow_o} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got valid=%0b cnt=%0d drop=%0d exp all zero", evt_valid_o, fifo_count_o, drop_count_o);
    end
  endtask
  task automatic test_single();
    do_reset();
    while (ts != 200) cycle(0, 0, 0, 0);
    cycle(1, 9'd53, 5'b00011, 0);
    vectors++;
    if ({evt_valid_o, evt_num_o, evt_time_o, evt_offset_o, evt_matched_o} !== {1'b1, 16'd0, 32'd200, 9'd53, 5'd3}) begin
      miscompares++;
      $display("FAIL single: got v=%0b num=%0d time=%0d off=%0d m=%0d exp v=1 num=0 time=200 off=53 m=3",
               evt_valid_o, evt_num_o, evt_time_o, evt_offset_o, evt_matched_o);
    end
    cycle(0, 0, 0, 0);
    vectors++;
    if (evt_time_o !== 32'd200) begin
      miscompares++; $display("FAIL single_hold: got time=%0d exp 200", evt_time_o);
    end
    cycle(0, 0, 0, 1);
    vectors++;
    if (evt_valid_o !== 1'b0 || fifo_count_o !== 5'd0) begin
      miscompares++; $display("FAIL single_pop: got v=%0b cnt=%0d exp v=0 cnt=0", evt_valid_o, fifo_count_o);
    end
  endtask
  task automatic test_overflow();
    logic [31:0] t0;
    do_reset();
    for (int i = 0; i < 18; i++) cycle(1, 9'(i), 5'(i), 0);
    vectors++;
    if (fifo_count_o !== 5'd16 || drop_count_o !== 16'd2 || overflow_o !== 1'b1) begin
      miscompares++; $display("FAIL overflow: got cnt=%0d drop=%0d ovf=%0b exp cnt=16 drop=2 ovf=1", fifo_count_o, drop_count_o, overflow_o);
    end
    t0 = evt_time_o;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (evt_num_o !== 16'(i) || evt_time_o !== t0 + 32'(i)) begin
        miscompares++; $display("FAIL drain_order: got num=%0d time=%0d exp num=%0d time=%0d", evt_num_o, evt_time_o, i, t0 + 32'(i));
      end
      cycle(0, 0, 0, 1);
    end
    vectors++;
    if (evt_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      miscompares++; $display("FAIL drain_end: got v=%0b ovf=%0b exp v=0 ovf=1", evt_valid_o, overflow_o);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 9'd1, 5'd1, 0);
    cycle(1, 9'd7, 5'd31, 1);
    vectors++;
    if (fifo_count_o !== 5'd16 || drop_count_o !== 16'd0) begin
      miscompares++; $display("FAIL full_pushpop: got cnt=%0d drop=%0d exp cnt=16 drop=0", fifo_count_o, drop_count_o);
    end
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 1);
    vectors++;
    if (evt_num_o !== 16'd16 || evt_offset_o !== 9'd7 || fifo_count_o !== 5'd1) begin
      miscompares++; $display("FAIL full_last: got num=%0d off=%0d cnt=%0d exp num=16 off=7 cnt=1", evt_num_o, evt_offset_o, fifo_count_o);
    end
    cycle(0, 0, 0, 1);
  endtask
  task automatic test_disable();
    do_reset();
    disable_i = 1; disable_ce_i = 1;
    cycle(0, 0, 0, 0);
    disable_ce_i = 0; disable_i = 0;
    for (int i = 0; i < 3; i++) cycle(1, 9'd2, 5'd2, 0);
    vectors++;
    if (fifo_count_o !== 5'd0 || drop_count_o !== 16'd0) begin
      miscompares++; $display("FAIL disabled: got cnt=%0d drop=%0d exp cnt=0 drop=0", fifo_count_o, drop_count_o);
    end
    disable_ce_i = 1;
    cycle(0, 0, 0, 0);
    disable_ce_i = 0; disable_i = 1;
    cycle(1, 9'd4, 5'd4, 0);
    disable_i = 0;
    vectors++;
    if (fifo_count_o !== 5'd1 || evt_num_o !== 16'd0 || drop_count_o !== 16'd0) begin
      miscompares++; $display("FAIL enabled: got cnt=%0d num=%0d drop=%0d exp cnt=1 num=0 drop=0", fifo_count_o, evt_num_o, drop_count_o);
    end
    cycle(0, 0, 0, 1);
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 9'd9, 5'd9, 0);
    rst_i = 1;
    cycle(1, 9'd9, 5'd9, 0);
    vectors++;
    if ({evt_valid_o, evt_num_o, evt_time_o, evt_offset_o, evt_matched_o, fifo_count_o, drop_count_o, overflow_o} !== '0) begin
      miscompares++; $display("FAIL reset_mid: got v=%0b cnt=%0d num=%0d exp all zero", evt_valid_o, fifo_count_o, evt_num_o);
    end
    rst_i = 0;
    cycle(1, 9'd11, 5'd1, 0);
    vectors++;
    if (evt_num_o !== 16'd0 || evt_time_o !== 32'd0 || evt_offset_o !== 9'd11 || fifo_count_o !== 5'd1) begin
      miscompares++; $display("FAIL reset_first: got num=%0d time=%0d off=%0d cnt=%0d exp num=0 time=0 off=11 cnt=1",
                              evt_num_o, evt_time_o, evt_offset_o, fifo_count_o);
    end
    cycle(0, 0, 0, 1);
  endtask
  task automatic test_wrap();
    do_reset();
    for (int c = 0; c <= 28; c++) begin
      t1_w = (c % 7 == 0);
      tick();
    end
    t1_w = 0;
    vectors++;
    if (cnt_w !== 5'd5) begin
      miscompares++; $display("FAIL wrap_count: got %0d exp 5", cnt_w);
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (valid_w !== 1'b1 || num_w !== 2'(k % 4) || time_w !== 4'((7 * k) % 16)) begin
        miscompares++; $display("FAIL wrap_event%0d: got v=%0b num=%0d time=%0d exp v=1 num=%0d time=%0d",
                                k, valid_w, num_w, time_w, k % 4, (7 * k) % 16);
      end
      ready_w = 1;
      tick();
      ready_w = 0;
    end
    vectors++;
    if (valid_w !== 1'b0) begin
      miscompares++; $display("FAIL wrap_empty: got v=%0b exp 0", valid_w);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
